scan_select_mux: RTL and testbench



---
 rtl/scan_select_mux_pkg.sv | 12 +
 rtl/scan_select_mux_if.sv | 30 +++
 rtl/scan_select_mux_tick_gen.sv | 29 ++
 rtl/scan_select_mux.sv | 77 +++++++
 tb/tb_scan_select_mux.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/scan_select_mux_pkg.sv
// Shared constants and helpers for the scan/select mux family.
package scan_select_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_select_mux_if.sv
// Channel data, select/mode controls and registered results of the scan/select mux.
interface scan_select_mux_if
  import scan_select_mux_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 1
);

  localparam int SEL_W = clog2_min1(N);

  logic [N*W-1:0]   din;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic             hold;
  logic [W-1:0]     dout;
  logic [SEL_W-1:0] cur_sel;
  logic             sel_err;
  logic             scan_tick;

  modport master (
    output din, sel, mode, hold,
    input  dout, cur_sel, sel_err, scan_tick
  );

  modport slave (
    input  din, sel, mode, hold,
    output dout, cur_sel, sel_err, scan_tick
  );

endinterface

// File: rtl/scan_select_mux_tick_gen.sv
// Scan-rate prescaler: counts 0..DIV-1 while enabled and flags the terminal cycle.
module scan_select_mux_tick_gen
  import scan_select_mux_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_select_mux.sv
// Registered N-channel selector with manual select or timed auto-scan of all channels.
module scan_select_mux
  import scan_select_mux_pkg::*;
#(
  parameter int N   = 7,
  parameter int W   = 1,
  parameter int DIV = 50_000_000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  scan_select_mux_if.slave bus
);

  localparam int               SEL_W = clog2_min1(N);
  localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

  logic             scan_en;
  logic             pre_clr;
  logic             tick;
  logic             sel_oob;
  logic             cur_oob;
  logic [SEL_W-1:0] idx_next;
  logic [W-1:0]     data_next;

  assign scan_en = (bus.mode == MODE_SCAN) && !bus.hold;
  assign pre_clr = (bus.mode == MODE_MANUAL);
  assign sel_oob = ({1'b0, bus.sel} >= N_EXT);
  assign cur_oob = ({1'b0, bus.cur_sel} >= N_EXT);

  scan_select_mux_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (CLOCK_50),
    .rst  (reset),
    .en   (scan_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // An errored manual select can leave cur_sel out of range; scan restarts at 0.
  always_comb begin
    idx_next = bus.cur_sel;
    if (bus.mode == MODE_MANUAL) begin
      idx_next = bus.sel;
    end else if (cur_oob) begin
      idx_next = '0;
    end else if (tick) begin
      idx_next = (bus.cur_sel == LAST) ? '0 : bus.cur_sel + 1'b1;
    end
  end

  // Out-of-range indices match no channel and therefore yield zero data.
  always_comb begin
    data_next = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_next == SEL_W'(k)) begin
        data_next = bus.din[k*W +: W];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bus.dout      <= '0;
      bus.cur_sel   <= '0;
      bus.sel_err   <= 1'b0;
      bus.scan_tick <= 1'b0;
    end else begin
      bus.dout      <= data_next;
      bus.cur_sel   <= idx_next;
      bus.sel_err   <= (bus.mode == MODE_MANUAL) && sel_oob;
      bus.scan_tick <= tick;
    end
  end

endmodule

// File: tb/tb_scan_select_mux.sv
// Directed checks of scan_select_mux: a 7x4-bit DIV=4 build and a 1-channel DIV=1 build.
module tb_scan_select_mux;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  scan_select_mux_if #(.N(7), .W(4)) ifa ();
  scan_select_mux_if #(.N(1), .W(4)) ifb ();

  scan_select_mux #(.N(7), .W(4), .DIV(4)) dut_a (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (ifa)
  );

  scan_select_mux #(.N(1), .W(4), .DIV(1)) dut_b (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int cur, input int dout, input int err,
                       input int tck);
    chk({tag, ".cur_sel"}, 32'(ifa.cur_sel), 32'(cur));
    chk({tag, ".dout"}, 32'(ifa.dout), 32'(dout));
    chk({tag, ".sel_err"}, 32'(ifa.sel_err), 32'(err));
    chk({tag, ".scan_tick"}, 32'(ifa.scan_tick), 32'(tck));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int exp_cur;
    checks = 0;
    errors = 0;

    // Reset held 3 cycles with arbitrary inputs
    reset    = 1'b1;
    ifa.din  = 28'hABCDEF1;
    ifa.sel  = 3'd5;
    ifa.mode = 1'b0;
    ifa.hold = 1'b0;
    ifb.din  = 4'h9;
    ifb.sel  = 1'b0;
    ifb.mode = 1'b1;
    ifb.hold = 1'b0;
    repeat (3) step();
    chk_a("reset", 0, 0, 0, 0);
    chk("reset_b.cur_sel", 32'(ifb.cur_sel), 32'd0);
    chk("reset_b.scan_tick", 32'(ifb.scan_tick), 32'd0);

    // Manual select, channel k holds k+1
    ifa.din = 28'h7654321;
    ifa.sel = 3'd3;
    reset   = 1'b0;
    step();
    chk_a("man_sel3", 3, 4, 0, 0);
    ifa.sel = 3'd7;
    step();
    chk_a("man_sel7", 7, 0, 1, 0);
    ifa.sel = 3'd6;
    step();
    chk_a("man_sel6", 6, 7, 0, 0);

    // Scan from index 5, wrapping through 6 -> 0 -> 1
    ifa.sel = 3'd5;
    step();
    chk_a("man_sel5", 5, 6, 0, 0);
    ifa.mode = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_cur = (i < 4) ? 5 : (i < 8) ? 6 : (i < 12) ? 0 : 1;
      chk_a($sformatf("scan_c%0d", i), exp_cur, exp_cur + 1, 0, (i % 4 == 0) ? 1 : 0);
    end

    // Hold with prescaler at 2
    step();
    step();
    chk_a("pre_hold", 1, 2, 0, 0);
    ifa.hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_a($sformatf("hold_c%0d", i), 1, 2, 0, 0);
    end
    ifa.din = 28'h76543F1;
    step();
    chk_a("hold_live_din", 1, 15, 0, 0);
    ifa.din  = 28'h7654321;
    ifa.hold = 1'b0;
    step();
    chk_a("release_c1", 1, 2, 0, 0);
    step();
    chk_a("release_tick", 2, 3, 0, 1);
    step();
    chk_a("release_after", 2, 3, 0, 0);

    // Errored manual select then switch to scan
    ifa.mode = 1'b0;
    ifa.sel  = 3'd7;
    step();
    chk_a("err_manual", 7, 0, 1, 0);
    ifa.mode = 1'b1;
    step();
    chk_a("err_to_scan", 0, 1, 0, 0);
    for (int i = 2; i <= 3; i++) begin
      step();
      chk_a($sformatf("err_scan_c%0d", i), 0, 1, 0, 0);
    end
    step();
    chk_a("err_scan_tick", 1, 2, 0, 1);

    // Reset mid-scan at index 4
    repeat (12) step();
    chk_a("at_idx4", 4, 5, 0, 1);
    step();
    reset = 1'b1;
    step();
    chk_a("mid_reset", 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_a($sformatf("post_reset_c%0d", i), 0, 1, 0, 0);
    end
    step();
    chk_a("post_reset_tick", 1, 2, 0, 1);

    // Single-channel, DIV=1 build
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("n1_tick_c%0d", i), 32'(ifb.scan_tick), 32'd1);
      chk($sformatf("n1_cur_c%0d", i), 32'(ifb.cur_sel), 32'd0);
      chk($sformatf("n1_dout_c%0d", i), 32'(ifb.dout), 32'h9);
    end
    ifb.din = 4'h5;
    step();
    chk("n1_dout_new", 32'(ifb.dout), 32'h5);
    ifb.hold = 1'b1;
    step();
    chk("n1_hold_tick", 32'(ifb.scan_tick), 32'd0);
    ifb.hold = 1'b0;
    ifb.mode = 1'b0;
    ifb.sel  = 1'b1;
    step();
    chk("n1_oob_err", 32'(ifb.sel_err), 32'd1);
    chk("n1_oob_dout", 32'(ifb.dout), 32'd0);
    chk("n1_oob_tick", 32'(ifb.scan_tick), 32'd0);
    ifb.mode = 1'b1;
    step();
    chk("n1_rescan_cur", 32'(ifb.cur_sel), 32'd0);
    chk("n1_rescan_err", 32'(ifb.sel_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
